// File: rtl/adc_lvds_tx_emu.sv
// Serializer emulating the ADC's 1-wire LVDS output: a frame clock plus one serial
// data lane per channel, one bit per SysClk, fed from user samples or test patterns.
module adc_lvds_tx_emu #(
  parameter int C_AdcChnls       = 8,
  parameter int C_AdcBits        = 14,
  parameter int C_AdcMsbOrLsbFst = 1
) (
  input  logic                    SysClk,
  input  logic                    SysRst_n,
  input  logic                    TxEna,
  input  logic [1:0]              PatSel,
  input  logic [C_AdcBits-1:0]    FixedPat,
  input  logic [16*C_AdcChnls-1:0] SmplData,
  input  logic                    SmplValid,
  output logic                    SmplReady,
  output logic                    TxFrmClk,
  output logic [C_AdcChnls-1:0]   TxData,
  output logic                    TxFrmStart,
  output logic                    Underrun,
  input  logic                    UnderrunClr
);

  localparam int CntW     = (C_AdcBits > 1) ? $clog2(C_AdcBits) : 1;
  localparam int HalfBits = (C_AdcBits + 1) / 2;

  localparam logic [CntW-1:0]       LastCnt = CntW'(C_AdcBits - 1);
  localparam logic [CntW-1:0]       HalfCnt = CntW'(HalfBits);
  localparam logic [2*HalfBits-1:0] ChkRep  = {HalfBits{2'b10}};
  localparam logic [C_AdcBits-1:0]  ChkWord = ChkRep[C_AdcBits-1:0];

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  typedef logic [C_AdcBits-1:0] word_t;

  state_t          state, state_nxt;
  logic [CntW-1:0] bit_cnt;
  word_t           ramp_cnt;
  logic            chk_phase;
  word_t           shift_reg [C_AdcChnls];
  word_t           hold_word [C_AdcChnls];
  word_t           load_word [C_AdcChnls];
  logic            last_bit, load_evt, user_load, user_miss;

  // Only the low C_AdcBits of each 16-bit channel slot carry sample data.
  logic unused_smpl_bits;
  assign unused_smpl_bits = ^SmplData;

  // A new frame loads from IDLE, or seamlessly on the last bit of the current frame.
  always_comb begin
    last_bit  = (state == ST_SHIFT) && (bit_cnt == LastCnt);
    load_evt  = TxEna && ((state == ST_IDLE) || last_bit);
    user_load = load_evt && (PatSel == 2'd0);
    user_miss = user_load && !SmplValid;
  end

  assign SmplReady = user_load && SmplValid;

  always_ff @(posedge SysClk or negedge SysRst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!SysRst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nxt = state;
    if (load_evt)      state_nxt = ST_SHIFT;
    else if (last_bit) state_nxt = ST_IDLE;
  end

  always_comb begin
    for (int c = 0; c < C_AdcChnls; c++) begin
      load_word[c] = '0;
      unique case (PatSel)
        2'd0:    load_word[c] = SmplValid ? SmplData[16*c +: C_AdcBits] : hold_word[c];
        2'd1:    load_word[c] = ramp_cnt + word_t'(c);
        2'd2:    load_word[c] = FixedPat;
        default: load_word[c] = chk_phase ? ~ChkWord : ChkWord;
      endcase
    end
  end

  always_ff @(posedge SysClk or negedge SysRst_n) begin
    if (!SysRst_n) begin
      bit_cnt   <= '0;
      ramp_cnt  <= '0;
      chk_phase <= 1'b0;
      // NOTE: the per-channel word arrays are reset too, so an underrun before the first
      // valid sample retransmits a defined all-zero word.
      for (int c = 0; c < C_AdcChnls; c++) begin
        shift_reg[c] <= '0;
        hold_word[c] <= '0;
      end
    end else if (load_evt) begin
      bit_cnt <= '0;
      for (int c = 0; c < C_AdcChnls; c++) begin
        shift_reg[c] <= load_word[c];
        if (user_load && SmplValid) hold_word[c] <= load_word[c];
      end
      if (PatSel == 2'd1) ramp_cnt  <= ramp_cnt + word_t'(1);
      if (PatSel == 2'd3) chk_phase <= ~chk_phase;
    end else if (last_bit) begin
      // Frame done with TxEna low: patterns restart from their origin on re-enable.
      bit_cnt   <= '0;
      ramp_cnt  <= '0;
      chk_phase <= 1'b0;
    end else if (state == ST_SHIFT) begin
      bit_cnt <= bit_cnt + CntW'(1);
      for (int c = 0; c < C_AdcChnls; c++)
        shift_reg[c] <= (C_AdcMsbOrLsbFst != 0) ? (shift_reg[c] >> 1) : (shift_reg[c] << 1);
    end
  end

  // Sticky underrun; a new underrun wins over a simultaneous clear.
  always_ff @(posedge SysClk or negedge SysRst_n) begin
    if (!SysRst_n)        Underrun <= 1'b0;
    else if (user_miss)   Underrun <= 1'b1;
    else if (UnderrunClr) Underrun <= 1'b0;
  end

  always_comb begin
    TxFrmClk   = (state == ST_SHIFT) && (bit_cnt < HalfCnt);
    TxFrmStart = (state == ST_SHIFT) && (bit_cnt == '0);
    for (int c = 0; c < C_AdcChnls; c++)
      TxData[c] = (state == ST_SHIFT) &&
                  ((C_AdcMsbOrLsbFst != 0) ? shift_reg[c][0] : shift_reg[c][C_AdcBits-1]);
  end

endmodule
